hw_timer_mc: RTL

HW_TIMER_MC -- requirements
Module: hw_timer_mc

---
 rtl/hw_timer_pkg.sv | 44 ++++
 rtl/hw_timer_channel.sv | 129 ++++++++++++
 rtl/hw_timer_mc.sv | 90 +++++++++
 3 files changed

// File: rtl/hw_timer_pkg.sv
// Shared definitions for the multi-channel timer: register map, bit
// positions inside STATUS/CONTROL, and helpers that build read words.
package hw_timer_pkg;

  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,
    REG_CONTROL = 2'd1,
    REG_PERIOD  = 2'd2,
    REG_SNAP    = 2'd3
  } reg_off_e;

  localparam int STATUS_TO_BIT  = 0;
  localparam int STATUS_RUN_BIT = 1;

  localparam int CTRL_ITO_BIT   = 0;
  localparam int CTRL_CONT_BIT  = 1;
  localparam int CTRL_START_BIT = 2;
  localparam int CTRL_STOP_BIT  = 3;

  localparam int PRESCALE_LSB   = 8;
  localparam int PRESCALE_MSB   = 15;
  localparam int PRESCALE_W     = PRESCALE_MSB - PRESCALE_LSB + 1;

  // STATUS read word: only TO and RUN are visible.
  function automatic logic [31:0] pack_status(input logic to, input logic run);
    logic [31:0] w;
    w                 = '0;
    w[STATUS_TO_BIT]  = to;
    w[STATUS_RUN_BIT] = run;
    return w;
  endfunction

  // CONTROL read word: START/STOP are strobes and always read back as 0.
  function automatic logic [31:0] pack_control(input logic ito, input logic cont,
                                               input logic [PRESCALE_W-1:0] prescale);
    logic [31:0] w;
    w                             = '0;
    w[CTRL_ITO_BIT]               = ito;
    w[CTRL_CONT_BIT]              = cont;
    w[PRESCALE_MSB:PRESCALE_LSB]  = prescale;
    return w;
  endfunction

endpackage

// File: rtl/hw_timer_channel.sv
// One timer channel: prescaler, down-counter, STATUS/CONTROL/PERIOD/SNAP
// registers and the channel interrupt.
module hw_timer_channel
  import hw_timer_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter logic [31:0] RESET_PERIOD = 32'h02FAF07F
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_status_i,
  input  logic        wr_control_i,
  input  logic        wr_period_i,
  input  logic        wr_snap_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] status_o,
  output logic [31:0] control_o,
  output logic [31:0] period_o,
  output logic [31:0] snap_o,
  output logic        irq_o
);

  localparam logic [CNT_W-1:0] RST_VAL = RESET_PERIOD[CNT_W-1:0];
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      period_q, period_d;
  logic [CNT_W-1:0]      snap_q, snap_d;
  logic [PRESCALE_W-1:0] psc_q, psc_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  run_q, run_d;
  logic                  to_q, to_d;
  logic                  ito_q, ito_d;
  logic                  cont_q, cont_d;
  logic                  load_pend_q, load_pend_d;
  logic                  tick;
  logic                  unused_wdata;

  assign unused_wdata = ^wdata_i;

  // A PERIOD write stops the channel in the same cycle, so that cycle must
  // not advance the counter or raise a timeout.
  assign tick = run_q && (psc_q == '0) && !wr_period_i;

  // Next-state for prescaler, counter and all software-visible registers.
  always_comb begin
    // NOTE: every _d takes its hold value first so no path leaves it unassigned (no latch).
    cnt_d       = cnt_q;
    period_d    = period_q;
    snap_d      = snap_q;
    psc_d       = psc_q;
    prescale_d  = prescale_q;
    run_d       = run_q;
    to_d        = to_q;
    ito_d       = ito_q;
    cont_d      = cont_q;
    load_pend_d = 1'b0;

    if (load_pend_q) begin
      cnt_d = period_q;
      psc_d = prescale_q;
    end else if (run_q) begin
      psc_d = (psc_q == '0) ? prescale_q : psc_q - PRESCALE_W'(1);
      if (tick) begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else begin
          cnt_d = period_q;
          if (!cont_q) run_d = 1'b0;
        end
      end
    end

    // Timeout beats a simultaneous clear so no event is lost.
    if (wr_status_i)            to_d = 1'b0;
    if (tick && (cnt_q == ONE)) to_d = 1'b1;

    if (wr_control_i) begin
      ito_d      = wdata_i[CTRL_ITO_BIT];
      cont_d     = wdata_i[CTRL_CONT_BIT];
      prescale_d = wdata_i[PRESCALE_MSB:PRESCALE_LSB];
      if (wdata_i[CTRL_START_BIT])     run_d = 1'b1;
      else if (wdata_i[CTRL_STOP_BIT]) run_d = 1'b0;
    end

    if (wr_period_i) begin
      period_d    = wdata_i[CNT_W-1:0];
      run_d       = 1'b0;
      load_pend_d = 1'b1;
    end

    if (wr_snap_i) snap_d = cnt_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset_n) begin
      cnt_q       <= RST_VAL;
      period_q    <= RST_VAL;
      snap_q      <= '0;
      psc_q       <= '0;
      prescale_q  <= '0;
      run_q       <= 1'b0;
      to_q        <= 1'b0;
      ito_q       <= 1'b0;
      cont_q      <= 1'b0;
      load_pend_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      snap_q      <= snap_d;
      psc_q       <= psc_d;
      prescale_q  <= prescale_d;
      run_q       <= run_d;
      to_q        <= to_d;
      ito_q       <= ito_d;
      cont_q      <= cont_d;
      load_pend_q <= load_pend_d;
    end
  end

  assign status_o  = pack_status(to_q, run_q);
  assign control_o = pack_control(ito_q, cont_q, prescale_q);
  assign period_o  = 32'(period_q);
  assign snap_o    = 32'(snap_q);
  assign irq_o     = to_q & ito_q;

endmodule

// File: rtl/hw_timer_mc.sv
// Multi-channel timer top: address decode, registered read mux and the
// interrupt OR over NUM_CH independent channels.
module hw_timer_mc
  import hw_timer_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 32,
  parameter logic [31:0] RESET_PERIOD = 32'h02FAF07F
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       chipselect,
  input  logic                       write_n,
  input  logic [$clog2(NUM_CH)+1:0]  address,
  input  logic [31:0]                writedata,
  output logic [31:0]                readdata,
  output logic [NUM_CH-1:0]          irq_vec,
  output logic                       irq
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int AW   = CH_W + 2;

  logic [3:0]  ch_sel;
  reg_off_e    off;
  logic        wr_en;
  logic [31:0] status_w  [NUM_CH];
  logic [31:0] control_w [NUM_CH];
  logic [31:0] period_w  [NUM_CH];
  logic [31:0] snap_w    [NUM_CH];
  logic [31:0] readdata_q, readdata_d;

  // A single-channel build has no channel field in the address.
  if (CH_W == 0) begin : g_one_ch
    assign ch_sel = '0;
  end else begin : g_multi_ch
    assign ch_sel = 4'(address[AW-1:2]);
  end

  assign off   = reg_off_e'(address[1:0]);
  assign wr_en = chipselect && !write_n && (ch_sel < 4'(NUM_CH));

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic hit;
    assign hit = wr_en && (ch_sel == 4'(i));

    hw_timer_channel #(
      .CNT_W        (CNT_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .wr_status_i  (hit && (off == REG_STATUS)),
      .wr_control_i (hit && (off == REG_CONTROL)),
      .wr_period_i  (hit && (off == REG_PERIOD)),
      .wr_snap_i    (hit && (off == REG_SNAP)),
      .wdata_i      (writedata),
      .status_o     (status_w[i]),
      .control_o    (control_w[i]),
      .period_o     (period_w[i]),
      .snap_o       (snap_w[i]),
      .irq_o        (irq_vec[i])
    );
  end

  // Read mux; an out-of-range channel index falls through to zero.
  always_comb begin
    readdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == 4'(i)) begin
        case (off)
          REG_STATUS:  readdata_d = status_w[i];
          REG_CONTROL: readdata_d = control_w[i];
          REG_PERIOD:  readdata_d = period_w[i];
          default:     readdata_d = snap_w[i];
        endcase
      end
    end
  end

  // Read data is registered every cycle, independent of chipselect.
  always_ff @(posedge clk) begin
    if (!reset_n) readdata_q <= '0;
    else          readdata_q <= readdata_d;
  end

  assign readdata = readdata_q;
  assign irq      = |irq_vec;

endmodule
